// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Purpose  : Fetch-stage branch predictor. It uses a direct-mapped BTB with a
//            2-bit saturating counter per entry. Lookup is combinational. It
//            trains on the resolution returned from EX and flags mispredicts
//            together with the correct redirect PC.
// Options  : BP_PERF_CNT_EN - when defined, builds the 32-bit branch count and
//            mispredict count performance counters. When undefined, both
//            counter outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int INDEX_W = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] fetch_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_is_br_i,
  input  logic        upd_is_uncbr_i,
  input  logic        upd_true_taken_i,
  input  logic [31:0] upd_target_i,
  input  logic        upd_pred_taken_i,
  input  logic [31:0] upd_pred_target_i,
  output logic        mispredict_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] perf_br_cnt_o,
  output logic [31:0] perf_miss_cnt_o
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;

  // Counter encodings: a fresh conditional entry starts weakly not-taken
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // BTB storage
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic             uncond_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Lookup and update addressing
  logic [INDEX_W-1:0] fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               fetch_hit;
  logic               upd_hit;
  logic               br;
  logic               false_hit;
  logic [1:0]         ctr_base;
  logic [1:0]         ctr_next;
  logic               unused_pc_bits;

  assign fetch_idx = fetch_pc_i[INDEX_W+1:2];
  assign fetch_tag = fetch_pc_i[31:INDEX_W+2];
  assign upd_idx   = upd_pc_i[INDEX_W+1:2];
  assign upd_tag   = upd_pc_i[31:INDEX_W+2];

  // Instructions are word aligned, so the low PC bits carry no information
  assign unused_pc_bits = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

  // Combinational fetch lookup. It reads the pre-update table, so there is no bypass.
  assign fetch_hit     = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken_o  = fetch_hit && (uncond_q[fetch_idx] || ctr_q[fetch_idx][1]);
  assign pred_target_o = pred_taken_o ? target_q[fetch_idx] : (fetch_pc_i + 32'd4);

  // Resolution classification
  assign br        = upd_valid_i && (upd_is_br_i || upd_is_uncbr_i);
  assign false_hit = upd_valid_i && !(upd_is_br_i || upd_is_uncbr_i) && upd_pred_taken_i;
  assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Mispredict detection; held low while the table is being reset
  always_comb begin
    mispredict_o = 1'b0;
    if (br && (upd_pred_taken_i != upd_true_taken_i)) begin
      mispredict_o = 1'b1;
    end else if (br && upd_pred_taken_i && upd_true_taken_i &&
                 (upd_pred_target_i != upd_target_i)) begin
      mispredict_o = 1'b1;
    end else if (false_hit) begin
      mispredict_o = 1'b1;
    end
    if (rst_i) begin
      mispredict_o = 1'b0;
    end
  end

  assign redirect_pc_o = (br && upd_true_taken_i) ? upd_target_i : (upd_pc_i + 32'd4);

  // Next counter value. A replaced entry restarts weakly not-taken before this update.
  always_comb begin
    ctr_base = upd_hit ? ctr_q[upd_idx] : CTR_WNT;
    ctr_next = ctr_base;
    if (upd_is_uncbr_i) begin
      ctr_next = CTR_ST;
    end else if (upd_true_taken_i) begin
      ctr_next = (ctr_base == CTR_ST) ? CTR_ST : (ctr_base + 2'd1);
    end else begin
      ctr_next = (ctr_base == CTR_SNT) ? CTR_SNT : (ctr_base - 2'd1);
    end
  end

  // Table training. Async reset clears every entry at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        uncond_q[i] <= 1'b0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (br) begin
      valid_q[upd_idx]  <= 1'b1;
      tag_q[upd_idx]    <= upd_tag;
      target_q[upd_idx] <= upd_target_i;
      uncond_q[upd_idx] <= upd_is_uncbr_i;
      ctr_q[upd_idx]    <= ctr_next;
    end else if (false_hit) begin
      valid_q[upd_idx]  <= 1'b0;
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] br_cnt_q;
  logic [31:0] miss_cnt_q;

  // Performance counters; both wrap naturally at 32 bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (br) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (mispredict_o) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign perf_br_cnt_o   = br_cnt_q;
  assign perf_miss_cnt_o = miss_cnt_q;
`else
  assign perf_br_cnt_o   = 32'h0;
  assign perf_miss_cnt_o = 32'h0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Scoreboard bench for branch_predictor. It uses an independent
//            behavioural model of the predictor table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] fetch_pc_i = '0;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_is_br_i = 1'b0;
  logic        upd_is_uncbr_i = 1'b0;
  logic        upd_true_taken_i = 1'b0;
  logic [31:0] upd_target_i = '0;
  logic        upd_pred_taken_i = 1'b0;
  logic [31:0] upd_pred_target_i = '0;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] perf_br_cnt_o;
  logic [31:0] perf_miss_cnt_o;

  branch_predictor dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .fetch_pc_i       (fetch_pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .upd_valid_i      (upd_valid_i),
    .upd_pc_i         (upd_pc_i),
    .upd_is_br_i      (upd_is_br_i),
    .upd_is_uncbr_i   (upd_is_uncbr_i),
    .upd_true_taken_i (upd_true_taken_i),
    .upd_target_i     (upd_target_i),
    .upd_pred_taken_i (upd_pred_taken_i),
    .upd_pred_target_i(upd_pred_target_i),
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o),
    .perf_br_cnt_o    (perf_br_cnt_o),
    .perf_miss_cnt_o  (perf_miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Single comparison point for every check in the bench
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        pt;
    logic [31:0] ptg;
    logic        mp;
    logic [31:0] rd;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sb[$];

  // Reference table model
  bit        m_valid [64];
  bit [23:0] m_tag   [64];
  bit [31:0] m_tgt   [64];
  bit        m_unc   [64];
  bit [1:0]  m_ctr   [64];
  bit [31:0] m_brs;
  bit [31:0] m_miss;

  function automatic void model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_unc[i] = 0; m_ctr[i] = 2'b01;
    end
    m_brs = 0;
    m_miss = 0;
  endfunction

  // Build the expected outputs for the current inputs, then advance the model over the coming edge
  task automatic eval_and_push(input string name, input bit in_reset);
    exp_t e;
    int fi, ui;
    bit hit, br, fh, mp;
    bit [1:0] c;
    fi = int'(fetch_pc_i[7:2]);
    ui = int'(upd_pc_i[7:2]);
    hit = m_valid[fi] && (m_tag[fi] == fetch_pc_i[31:8]);
    e.name = name;
    e.pt   = hit && (m_unc[fi] || (m_ctr[fi] >= 2'd2));
    e.ptg  = e.pt ? m_tgt[fi] : fetch_pc_i + 32'd4;
    br = upd_valid_i && (upd_is_br_i || upd_is_uncbr_i);
    fh = upd_valid_i && !(upd_is_br_i || upd_is_uncbr_i) && upd_pred_taken_i;
    mp = (br && (upd_pred_taken_i != upd_true_taken_i)) ||
         (br && upd_pred_taken_i && upd_true_taken_i && (upd_pred_target_i != upd_target_i)) ||
         fh;
    if (in_reset) mp = 0;
    e.mp = mp;
    e.rd = (br && upd_true_taken_i) ? upd_target_i : upd_pc_i + 32'd4;
`ifdef BP_PERF_CNT_EN
    e.bc = m_brs;
    e.mc = m_miss;
`else
    e.bc = 0;
    e.mc = 0;
`endif
    sb.push_back(e);
    if (in_reset) return;
    if (br) begin
      m_brs++;
      hit = m_valid[ui] && (m_tag[ui] == upd_pc_i[31:8]);
      c = hit ? m_ctr[ui] : 2'b01;
      if (upd_is_uncbr_i) c = 2'b11;
      else if (upd_true_taken_i) c = (c == 2'b11) ? c : c + 2'd1;
      else c = (c == 2'b00) ? c : c - 2'd1;
      m_valid[ui] = 1; m_tag[ui] = upd_pc_i[31:8]; m_tgt[ui] = upd_target_i;
      m_unc[ui] = upd_is_uncbr_i; m_ctr[ui] = c;
    end else if (fh) begin
      m_valid[ui] = 0;
    end
    if (mp) m_miss++;
  endtask

  // One bench cycle: drive after the edge, queue the expectation, sample at negedge
  task automatic cyc(input string name, input logic [31:0] fpc,
                     input bit uv, input logic [31:0] upc, input bit isbr, input bit isunc,
                     input bit tt, input logic [31:0] tgt, input bit ppt, input logic [31:0] ptgt);
    @(posedge clk_i);
    #1;
    rst_i = 0;
    fetch_pc_i = fpc; upd_valid_i = uv; upd_pc_i = upc; upd_is_br_i = isbr;
    upd_is_uncbr_i = isunc; upd_true_taken_i = tt; upd_target_i = tgt;
    upd_pred_taken_i = ppt; upd_pred_target_i = ptgt;
    eval_and_push(name, 0);
  endtask

  task automatic fetch(input string name, input logic [31:0] fpc);
    cyc(name, fpc, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  // Monitor: compare each queued expectation against the settled outputs
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".pred_taken"},  {31'b0, pred_taken_o}, {31'b0, e.pt});
      check({e.name, ".pred_target"}, pred_target_o, e.ptg);
      check({e.name, ".mispredict"},  {31'b0, mispredict_o}, {31'b0, e.mp});
      check({e.name, ".redirect"},    redirect_pc_o, e.rd);
      check({e.name, ".perf_br"},     perf_br_cnt_o, e.bc);
      check({e.name, ".perf_miss"},   perf_miss_cnt_o, e.mc);
    end
  end

  initial begin
    logic [31:0] pcs [4];
    logic [31:0] tgts [3];
    pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h104; pcs[3] = 32'hFFFF_FFFC;
    tgts[0] = 32'h80; tgts[1] = 32'h300; tgts[2] = 32'h0;
    model_clear();

    // Reset state, with a mispredicting update presented to prove the gating
    @(posedge clk_i);
    #1;
    fetch_pc_i = 32'h100; upd_valid_i = 1; upd_is_br_i = 1; upd_pc_i = 32'h100;
    upd_true_taken_i = 1; upd_target_i = 32'h80; upd_pred_taken_i = 0;
    eval_and_push("reset", 1);

    fetch("t1_fetch", 32'h100);
    cyc("t2_upd", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    fetch("t2_fetch", 32'h100);
    cyc("t3_tk1", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
    cyc("t3_tk2", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
    cyc("t3_tk3", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
    cyc("t3_nt1", 32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    fetch("t3_after_nt1", 32'h100);
    cyc("t3_nt2", 32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 1, 32'h80);
    fetch("t3_after_nt2", 32'h100);

    // Aliasing at index 0: 0x100 and 0x200 share the index but not the tag
    cyc("t4_retrain", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    fetch("t4_alias_fetch", 32'h200);
    cyc("t4_jal", 32'h200, 1, 32'h200, 0, 1, 1, 32'h300, 0, 32'h204);
    fetch("t4_old_pc", 32'h100);
    fetch("t4_new_pc", 32'h200);

    // Target mismatch with both predictions taken
    cyc("t4_tgt_miss", 32'h200, 1, 32'h200, 0, 1, 1, 32'h340, 1, 32'h300);

    // False alias hit on a non-branch
    cyc("t5_train", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    cyc("t5_train2", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 1, 32'h80);
    cyc("t5_false_hit", 32'h100, 1, 32'h100, 0, 0, 0, 32'h0, 1, 32'h80);
    fetch("t5_after", 32'h100);

    // Same-cycle read and update: old entry now, new entry next cycle
    cyc("t6_same_cycle", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    cyc("t6_same_cycle2", 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    fetch("t6_next", 32'h100);

    // Modulo PC arithmetic at the top of the address space
    fetch("wrap_fetch", 32'hFFFF_FFFC);
    cyc("wrap_nt", 32'h0, 1, 32'hFFFF_FFFC, 1, 0, 0, 32'h40, 1, 32'h40);

    // Randomised mix across a few PCs
    for (int i = 0; i < 60; i++) begin
      cyc("rand", pcs[$urandom_range(0, 3)], bit'($urandom_range(0, 1)),
          pcs[$urandom_range(0, 3)], bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
          bit'($urandom_range(0, 1)), tgts[$urandom_range(0, 2)],
          bit'($urandom_range(0, 1)), tgts[$urandom_range(0, 2)]);
    end

    // Reset mid-run: the table and counters clear immediately
    cyc("pre_rst", 32'h100, 1, 32'h100, 0, 1, 1, 32'h80, 0, 32'h104);
    @(posedge clk_i);
    #1;
    rst_i = 1;
    model_clear();
    fetch_pc_i = 32'h100; upd_valid_i = 1; upd_pc_i = 32'h100; upd_is_br_i = 1;
    upd_is_uncbr_i = 0; upd_true_taken_i = 1; upd_pred_taken_i = 0;
    eval_and_push("mid_rst", 1);
    fetch("post_rst_100", 32'h100);
    fetch("post_rst_200", 32'h200);

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
